// File: rtl/instruction_fetcher_pkg.sv
// Shared fetch-unit types and constants.
// Optional perf counters are enabled with IFETCH_PERF_EN.
package instruction_fetcher_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_BYTES = 8;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    OUT,
    DROP
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Instruction memory request/response bus.
// Master is the fetcher, slave is the memory.
interface instruction_fetcher_if;
  import instruction_fetcher_pkg::*;

  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [2*XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/instruction_fetcher.sv
// Dual-issue fetch unit: one outstanding 64-bit bundle request.
// IFETCH_PERF_EN adds perf_bundles / perf_stall_cycles counters.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [XLEN-1:0]       redirect_pc,
  instruction_fetcher_if.master mem,
  output logic [XLEN-1:0]       instructionA,
  output logic [XLEN-1:0]       instructionB,
  output logic [XLEN-1:0]       addressA,
  output logic [XLEN-1:0]       addressB,
  output logic                  instructionA_valid,
  output logic                  instructionB_valid
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           perf_bundles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  fetch_state_e    state;
  fetch_state_e    state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] aligned;
  logic [XLEN-1:0] redirect_al;
  logic            load;
  logic            out_go;
  logic            slot_a;
  logic            slot_b;
  logic            unused_bits;

  assign aligned     = align_pc(fetch_pc);
  assign redirect_al = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^{redirect_pc[1:0], fetch_pc[1:0]};

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    load    = 1'b0;
    if (flush) pc_n = redirect_al;
    unique case (state)
      REQ: begin
        if (!flush && mem.mem_ready) state_n = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_n = mem.mem_rvalid ? REQ : DROP;
        end else if (mem.mem_rvalid) begin
          load    = 1'b1;
          state_n = OUT;
        end
      end
      OUT: begin
        if (flush) begin
          state_n = REQ;
        end else if (!stall) begin
          pc_n    = aligned + XLEN'(FETCH_BYTES);
          state_n = REQ;
        end
      end
      DROP: begin
        if (mem.mem_rvalid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
  end

  // Stall only gates the valids; the bus never sees it.
  assign mem.mem_req  = (state == REQ) && !flush && !rst;
  assign mem.mem_addr = aligned;

  assign out_go = (state == OUT) && !stall && !flush && !rst;
  assign instructionA_valid = slot_a && out_go;
  assign instructionB_valid = slot_b && out_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      fetch_pc     <= RESET_PC;
      instructionA <= '0;
      instructionB <= '0;
      addressA     <= '0;
      addressB     <= '0;
      slot_a       <= 1'b0;
      slot_b       <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      if (load) begin
        slot_a <= 1'b1;
        if (!fetch_pc[2]) begin
          instructionA <= mem.mem_rdata[31:0];
          addressA     <= aligned;
          instructionB <= mem.mem_rdata[63:32];
          addressB     <= aligned + 32'd4;
          slot_b       <= 1'b1;
        end else begin
          instructionA <= mem.mem_rdata[63:32];
          addressA     <= aligned + 32'd4;
          instructionB <= '0;
          addressB     <= '0;
          slot_b       <= 1'b0;
        end
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bundles      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (out_go) perf_bundles <= perf_bundles + 32'd1;
      if ((state == OUT) && stall)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
